fetch_sequencer: RTL and testbench

//  Control FSM for the instruction-fetch stage. Each cycle it produces the 2-bit next-PC select, a PC hold and

---
 rtl/fetch_seq_pkg.sv | 26 ++
 rtl/fetch_seq_perf.sv | 38 +++
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared state codes, next-PC select codes and helpers for the fetch sequencer.
// Imported by fetch_sequencer and fetch_seq_perf.
package fetch_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t BOOT  = 3'd0;
  localparam state_t RUN   = 3'd1;
  localparam state_t FLUSH = 3'd2;
  localparam state_t STALL = 3'd3;
  localparam state_t HALT  = 3'd4;

  localparam logic [1:0] SEL_PC_INC  = 2'b00;
  localparam logic [1:0] SEL_JUMP    = 2'b01;
  localparam logic [1:0] SEL_REG     = 2'b10;
  localparam logic [1:0] SEL_RESTART = 2'b11;

  localparam int CNT_W  = 4;
  localparam int PERF_W = 16;

  // Saturating increment; holds at all-ones instead of wrapping to zero.
  function automatic logic [PERF_W-1:0] sat_inc16(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_seq_perf.sv
// Two 16-bit saturating event counters (redirects taken, PC-hold cycles).
// Only instantiated when FETCH_SEQ_PERF_EN is defined.
module fetch_seq_perf
  import fetch_seq_pkg::*;
(
  input  logic              reloj,
  input  logic              reset,
  input  logic              redir_i,
  input  logic              hold_i,
  output logic [PERF_W-1:0] redir_cnt_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  logic [1:0] inc;
  assign inc = {hold_i, redir_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [PERF_W-1:0] cnt_q;
      logic [PERF_W-1:0] cnt_d;

      assign cnt_d = inc[gi] ? sat_inc16(cnt_q) : cnt_q;

      always_ff @(posedge reloj) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign redir_cnt_o = g_cnt[0].cnt_q;
  assign stall_cnt_o = g_cnt[1].cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: next-PC select, PC hold and IF/ID, ID/EX flush strobes (Mealy outputs).
// Optional FETCH_SEQ_PERF_EN adds saturating redirect/stall counters; otherwise those ports read 0.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned PC_W         = 6,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic        jump_req,
  input  logic        jr_req,
  input  logic        stall_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic [1:0]  sel_dir,
  output logic        pc_hold,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [2:0]  state_o,
  output logic [15:0] redir_cnt,
  output logic [15:0] stall_cnt
);

  localparam logic [CNT_W-1:0] BOOT_LD  = BOOT_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] FLUSH_LD = FLUSH_CYCLES[CNT_W-1:0];

  generate
    if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || PC_W < 1)
    begin : g_param_err
      $error("fetch_sequencer: BOOT_CYCLES/FLUSH_CYCLES/PC_W out of range");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect;
  logic             redir_take;

  assign redirect = jr_req | jump_req;

  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q <= BOOT;
      cnt_q   <= BOOT_LD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Down counters stop at 1 -> leave state; a redirect during FLUSH reloads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        if (cnt_q <= 4'd1) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RUN: begin
        if (redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
        end else if (stall_req) begin
          state_d = STALL;
        end else if (halt_req) begin
          state_d = HALT;
        end
      end
      FLUSH: begin
        if (redirect)            cnt_d   = FLUSH_LD;
        else if (cnt_q <= 4'd1)  state_d = RUN;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      STALL: begin
        if (redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
        end else if (!stall_req) begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (resume) state_d = RUN;
      end
      default: begin
        state_d = BOOT;
        cnt_d   = BOOT_LD;
      end
    endcase
  end

  always_comb begin
    sel_dir    = SEL_PC_INC;
    pc_hold    = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    redir_take = 1'b0;
    case (state_q)
      BOOT: begin
        sel_dir    = SEL_RESTART;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      RUN, FLUSH, STALL: begin
        if (state_q == FLUSH) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end
        if (redirect) begin
          sel_dir    = jr_req ? SEL_REG : SEL_JUMP;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          redir_take = 1'b1;
        end else if (state_q != FLUSH && stall_req) begin
          // Load-use bubble: hold PC, squash ID/EX.
          pc_hold    = 1'b1;
          flush_idex = 1'b1;
        end else if (state_q == RUN && halt_req) begin
          pc_hold = 1'b1;
        end
      end
      HALT: begin
        pc_hold = ~resume;
      end
      default: begin
        sel_dir    = SEL_RESTART;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    endcase
  end

  assign state_o = state_q;

`ifdef FETCH_SEQ_PERF_EN
  fetch_seq_perf u_perf (
    .reloj       (reloj),
    .reset       (reset),
    .redir_i     (redir_take),
    .hold_i      (pc_hold),
    .redir_cnt_o (redir_cnt),
    .stall_cnt_o (stall_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf = redir_take;
  assign redir_cnt   = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: boot, redirects, priority, stall, halt and mid-state reset.
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        reloj = 1'b0;
  logic        reset, jump_req, jr_req, stall_req, halt_req, resume;
  logic [1:0]  sel_dir;
  logic        pc_hold, flush_ifid, flush_idex;
  logic [2:0]  state_o;
  logic [15:0] redir_cnt, stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 reloj = ~reloj;

  fetch_sequencer #(.PC_W(6), .BOOT_CYCLES(2), .FLUSH_CYCLES(1)) dut (
    .reloj      (reloj),
    .reset      (reset),
    .jump_req   (jump_req),
    .jr_req     (jr_req),
    .stall_req  (stall_req),
    .halt_req   (halt_req),
    .resume     (resume),
    .sel_dir    (sel_dir),
    .pc_hold    (pc_hold),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .state_o    (state_o),
    .redir_cnt  (redir_cnt),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  initial begin
    reset = 1'b1; jump_req = 1'b0; jr_req = 1'b0;
    stall_req = 1'b0; halt_req = 1'b0; resume = 1'b0;

    // 1: reset, then BOOT for 2 cycles ignoring requests, then RUN
    repeat (3) @(posedge reloj);
    #1;
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_sel", 16'(sel_dir), 16'd3);
    chk("rst_redir", redir_cnt, 16'd0);
    chk("rst_stall", stall_cnt, 16'd0);
    reset = 1'b0; jump_req = 1'b1; #1;
    chk("boot1_sel", 16'(sel_dir), 16'd3);
    chk("boot1_fifid", 16'(flush_ifid), 16'd1);
    chk("boot1_fidex", 16'(flush_idex), 16'd1);
    chk("boot1_hold", 16'(pc_hold), 16'd0);
    tick();
    chk("boot2_sel", 16'(sel_dir), 16'd3);
    chk("boot2_state", 16'(state_o), 16'd0);
    jump_req = 1'b0;
    tick();
    chk("run_state", 16'(state_o), 16'd1);
    chk("run_sel", 16'(sel_dir), 16'd0);
    chk("run_hold", 16'(pc_hold), 16'd0);
    chk("run_fifid", 16'(flush_ifid), 16'd0);
    chk("boot_redir", redir_cnt, 16'd0);

    // 2: single jump pulse
    jump_req = 1'b1; #1;
    chk("jmp_sel", 16'(sel_dir), 16'd1);
    chk("jmp_fifid", 16'(flush_ifid), 16'd1);
    chk("jmp_fidex", 16'(flush_idex), 16'd1);
    tick();
    jump_req = 1'b0; #1;
    chk("jmp_flush_state", 16'(state_o), 16'd2);
    chk("jmp_flush_sel", 16'(sel_dir), 16'd0);
    chk("jmp_flush_fifid", 16'(flush_ifid), 16'd1);
    tick();
    chk("jmp_back_run", 16'(state_o), 16'd1);
    chk("jmp_redir_cnt", redir_cnt, PERF ? 16'd1 : 16'd0);

    // 3: jr + jump + stall together -> register redirect only
    jr_req = 1'b1; jump_req = 1'b1; stall_req = 1'b1; #1;
    chk("pri_sel", 16'(sel_dir), 16'd2);
    chk("pri_hold", 16'(pc_hold), 16'd0);
    tick();
    jr_req = 1'b0; jump_req = 1'b0; stall_req = 1'b0; #1;
    chk("pri_state", 16'(state_o), 16'd2);
    tick();
    chk("pri_back_run", 16'(state_o), 16'd1);
    chk("pri_redir_cnt", redir_cnt, PERF ? 16'd2 : 16'd0);

    // 4: stall for 3 cycles
    stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stl%0d_hold", i), 16'(pc_hold), 16'd1);
      chk($sformatf("stl%0d_fidex", i), 16'(flush_idex), 16'd1);
      chk($sformatf("stl%0d_sel", i), 16'(sel_dir), 16'd0);
      tick();
    end
    stall_req = 1'b0; #1;
    chk("stl_end_state", 16'(state_o), 16'd3);
    chk("stl_end_hold", 16'(pc_hold), 16'd0);
    chk("stl_end_sel", 16'(sel_dir), 16'd0);
    tick();
    chk("stl_back_run", 16'(state_o), 16'd1);
    chk("stl_cnt", stall_cnt, PERF ? 16'd3 : 16'd0);

    // 5: halt, jumps ignored, resume
    halt_req = 1'b1; #1;
    chk("hlt_req_hold", 16'(pc_hold), 16'd1);
    tick();
    halt_req = 1'b0; jump_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hlt%0d_state", i), 16'(state_o), 16'd4);
      chk($sformatf("hlt%0d_hold", i), 16'(pc_hold), 16'd1);
      chk($sformatf("hlt%0d_sel", i), 16'(sel_dir), 16'd0);
      chk($sformatf("hlt%0d_fifid", i), 16'(flush_ifid), 16'd0);
      tick();
    end
    chk("hlt_redir_cnt", redir_cnt, PERF ? 16'd2 : 16'd0);
    chk("hlt_stall_cnt", stall_cnt, PERF ? 16'd9 : 16'd0);
    jump_req = 1'b0; resume = 1'b1; #1;
    chk("resume_sel", 16'(sel_dir), 16'd0);
    tick();
    resume = 1'b0; #1;
    chk("resume_state", 16'(state_o), 16'd1);

    // 6a: reset in FLUSH
    jump_req = 1'b1; #1;
    tick();
    jump_req = 1'b0; #1;
    chk("pre_rst_flush", 16'(state_o), 16'd2);
    reset = 1'b1; #1;
    tick();
    reset = 1'b0; #1;
    chk("rstf_state", 16'(state_o), 16'd0);
    chk("rstf_sel", 16'(sel_dir), 16'd3);
    chk("rstf_redir", redir_cnt, 16'd0);
    chk("rstf_stall", stall_cnt, 16'd0);
    tick();
    tick();
    chk("rstf_run", 16'(state_o), 16'd1);

    // 6b: reset in STALL
    stall_req = 1'b1; #1;
    tick();
    chk("pre_rst_stall", 16'(state_o), 16'd3);
    reset = 1'b1; #1;
    tick();
    reset = 1'b0; stall_req = 1'b0; #1;
    chk("rsts_state", 16'(state_o), 16'd0);
    chk("rsts_sel", 16'(sel_dir), 16'd3);
    chk("rsts_stall", stall_cnt, 16'd0);
    chk("rsts_redir", redir_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
